pic_seq_ctrl: RTL

- Multi-cycle control sequencer for the 12-bit-instruction accumulator CPU.
- Sits directly downstream of the instruction register (IR): consumes IR contents and the accumulator zero flag.
- Drives enables for the PC register, IR load, accumulator write, file-register RAM read/write and the accumulator input mux select.
- Replaces the free-running, every-cycle update with a fetch/decode/memory/execute sequence. Adds a ROM ready handshake, skip-next handling and a fetch timeout fault.

---
 rtl/pic_seq_ctrl_if.sv | 31 +++
 rtl/pic_seq_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pic_seq_ctrl_if.sv
// Control-sequencer bus: IR/flag inputs from the datapath and enables back to it.
// master = sequencer side, slave = datapath side.
interface pic_seq_ctrl_if;
   logic        run;
   logic        rom_ready;
   logic [11:0] ir;
   logic        acc_zero;
   logic        rom_oe;
   logic        ir_en;
   logic        pc_en;
   logic        pc_load;
   logic        acc_en;
   logic [1:0]  alu_sel;
   logic        ram_oe;
   logic        ram_we;
   logic        instr_done;
   logic        fault;
   logic [2:0]  state;

   modport master (
      input  run, rom_ready, ir, acc_zero,
      output rom_oe, ir_en, pc_en, pc_load, acc_en, alu_sel,
             ram_oe, ram_we, instr_done, fault, state
   );

   modport slave (
      output run, rom_ready, ir, acc_zero,
      input  rom_oe, ir_en, pc_en, pc_load, acc_en, alu_sel,
             ram_oe, ram_we, instr_done, fault, state
   );
endinterface

// File: rtl/pic_seq_ctrl.sv
// Fetch/decode/memory/execute sequencer for the 12-bit accumulator CPU.
// 3 cycles per instruction (3+RAM_LAT for RAM reads, 2 when skipped); stalls in FETCH on rom_ready, halts on timeout.
module pic_seq_ctrl #(
   parameter int unsigned RAM_LAT       = 2,
   parameter int unsigned FETCH_TIMEOUT = 8
) (
   input logic           CLK,
   input logic           RST,
   pic_seq_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      MEMRD  = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5
   } st_t;

   localparam logic [7:0] TMO_LAST  = 8'(FETCH_TIMEOUT - 1);
   localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);

   st_t        cur_st, nxt_st;
   logic [7:0] tmo_cnt, tmo_nxt;
   logic [3:0] wait_cnt, wait_nxt;
   logic       skip, skip_nxt;
   logic       fault_q, fault_nxt;

   logic       rom_oe, ir_en, pc_en, pc_load, acc_en, ram_oe, ram_we, instr_done;
   logic [1:0] alu_sel;

   logic [3:0] opc;
   logic       is_mem;
   assign opc    = bus.ir[11:8];
   assign is_mem = (opc == 4'b0010) || (opc == 4'b0011);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cur_st   <= IDLE;
         tmo_cnt  <= '0;
         wait_cnt <= '0;
         skip     <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         cur_st   <= nxt_st;
         tmo_cnt  <= tmo_nxt;
         wait_cnt <= wait_nxt;
         skip     <= skip_nxt;
         fault_q  <= fault_nxt;
      end
   end

   always_comb begin
      nxt_st     = cur_st;
      tmo_nxt    = tmo_cnt;
      wait_nxt   = wait_cnt;
      skip_nxt   = skip;
      fault_nxt  = fault_q;
      rom_oe     = 1'b0;
      ir_en      = 1'b0;
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      acc_en     = 1'b0;
      alu_sel    = 2'b00;
      ram_oe     = 1'b0;
      ram_we     = 1'b0;
      instr_done = 1'b0;

      case (cur_st)
         IDLE: begin
            if (bus.run) nxt_st = FETCH;
         end
         FETCH: begin
            rom_oe = 1'b1;
            if (bus.rom_ready) begin
               ir_en   = 1'b1;
               tmo_nxt = '0;
               nxt_st  = DECODE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_nxt   = '0;
               fault_nxt = 1'b1;
               nxt_st    = HALT;
            end else begin
               tmo_nxt = tmo_cnt + 8'd1;
            end
         end
         DECODE: begin
            // A pending skip retires this instruction here, bypassing EXEC entirely.
            if (skip) begin
               pc_en      = 1'b1;
               instr_done = 1'b1;
               skip_nxt   = 1'b0;
               nxt_st     = bus.run ? FETCH : IDLE;
            end else if (is_mem) begin
               ram_oe   = 1'b1;
               wait_nxt = WAIT_INIT;
               nxt_st   = MEMRD;
            end else begin
               nxt_st = EXEC;
            end
         end
         MEMRD: begin
            ram_oe = 1'b1;
            if (wait_cnt == 4'd0) nxt_st = EXEC;
            else                  wait_nxt = wait_cnt - 4'd1;
         end
         EXEC: begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
            case (opc)
               4'b0001: ram_we = 1'b1;
               4'b0010: begin ram_oe = 1'b1; acc_en = 1'b1; alu_sel = 2'b10; end
               4'b0011: begin ram_oe = 1'b1; acc_en = 1'b1; alu_sel = 2'b11; end
               4'b0100: begin acc_en = 1'b1; alu_sel = 2'b01; end
               4'b0101: skip_nxt = bus.acc_zero;
               4'b1010,
               4'b1011: pc_load = 1'b1;
               default: ;
            endcase
            nxt_st = bus.run ? FETCH : IDLE;
         end
         HALT: ;
         default: nxt_st = IDLE;
      endcase
   end

   assign bus.rom_oe     = rom_oe;
   assign bus.ir_en      = ir_en;
   assign bus.pc_en      = pc_en;
   assign bus.pc_load    = pc_load;
   assign bus.acc_en     = acc_en;
   assign bus.alu_sel    = alu_sel;
   assign bus.ram_oe     = ram_oe;
   assign bus.ram_we     = ram_we;
   assign bus.instr_done = instr_done;
   assign bus.fault      = fault_q;
   assign bus.state      = cur_st;
endmodule
